// File: rtl/fetch_issue_queue.sv
// Dual-issue fetch buffer: circular queue of fetched instructions feeding the
// two-slot D register, splitting intra-pair RAW hazards and system ops.
module fetch_issue_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [31:0]     fetch_inst0,
  input  logic [31:0]     fetch_inst1,
  input  logic            fetch_v0,
  input  logic            fetch_v1,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            enableD,
  output logic            enableD2,
  output logic [31:0]     InstrD1,
  output logic [31:0]     InstrD2,
  output logic [XLEN-1:0] PCD1,
  output logic [XLEN-1:0] PCD2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head, tail, headInc, tailInc;
  logic [CW-1:0] count;
  entry_t        entA, entB;
  logic          aSys, bSys, aWritesRd, rawHaz, pairOk, issue, enq;
  logic [1:0]    nEnq, nDeq;

  assign headInc = head + PW'(1);
  assign tailInc = tail + PW'(1);
  assign entA    = mem[head];
  assign entB    = mem[headInc];

  // Ready depends only on registered occupancy so fetch never sees hazard timing.
  assign fetch_ready = (CW'(DEPTH) - count) >= CW'(2);

  // Pair split: the hazard unit never compares the two D slots against each other.
  always_comb begin
    aSys      = entA.inst[6:0] == OP_SYS;
    bSys      = entB.inst[6:0] == OP_SYS;
    aWritesRd = (entA.inst[6:0] != OP_ST) && (entA.inst[6:0] != OP_BR);
    rawHaz    = aWritesRd && (entA.inst[11:7] != 5'd0) &&
                ((entA.inst[11:7] == entB.inst[19:15]) ||
                 (entA.inst[11:7] == entB.inst[24:20]));
    pairOk    = (count >= CW'(2)) && !aSys && !bSys && !rawHaz;
    issue     = !StallD && !FlushD && (count != '0);
    nDeq      = !issue ? 2'd0 : (pairOk ? 2'd2 : 2'd1);
    enq       = fetch_valid && fetch_ready && fetch_v0 && !FlushD;
    nEnq      = !enq ? 2'd0 : (fetch_v1 ? 2'd2 : 2'd1);
  end

  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      mem[tail] <= '{inst: fetch_inst0, pc: fetch_pc};
      if (fetch_v1) mem[tailInc] <= '{inst: fetch_inst1, pc: fetch_pc + XLEN'(4)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      enableD  <= 1'b0;
      enableD2 <= 1'b0;
      InstrD1  <= '0;
      InstrD2  <= '0;
      PCD1     <= '0;
      PCD2     <= '0;
    end else begin
      tail  <= tail + PW'(nEnq);
      head  <= head + PW'(nDeq);
      count <= count + CW'(nEnq) - CW'(nDeq);
      if (!StallD) begin
        enableD  <= issue;
        enableD2 <= issue && pairOk;
        InstrD1  <= issue ? entA.inst : '0;
        PCD1     <= issue ? entA.pc   : '0;
        InstrD2  <= (issue && pairOk) ? entB.inst : '0;
        PCD2     <= (issue && pairOk) ? entB.pc   : '0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_issue_queue.sv
// Directed bench for fetch_issue_queue: pairing, hazard splits, stall, flush,
// wrap-around streaming and reset priority.
module tb_fetch_issue_queue;
  localparam int XLEN = 64;
  localparam logic [31:0] ADD1  = 32'h003100B3; // add x1,x2,x3
  localparam logic [31:0] ADD4  = 32'h00628233; // add x4,x5,x6
  localparam logic [31:0] ADDI5 = 32'h00100293; // addi x5,x0,1
  localparam logic [31:0] ADD6  = 32'h00528333; // add x6,x5,x5
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ECALL = 32'h00000073;

  logic clk = 0, reset = 1;
  logic fetch_valid = 0, fetch_ready, fetch_v0 = 0, fetch_v1 = 0;
  logic [XLEN-1:0] fetch_pc = '0, PCD1, PCD2;
  logic [31:0] fetch_inst0 = '0, fetch_inst1 = '0, InstrD1, InstrD2;
  logic StallD = 0, FlushD = 0, enableD, enableD2;

  int total = 0, bad = 0;
  logic [63:0] expQ[$];

  fetch_issue_queue #(.DEPTH(8), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
    .fetch_v0(fetch_v0), .fetch_v1(fetch_v1), .StallD(StallD), .FlushD(FlushD),
    .enableD(enableD), .enableD2(enableD2), .InstrD1(InstrD1), .InstrD2(InstrD2),
    .PCD1(PCD1), .PCD2(PCD2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then return just after the edge.
  task automatic step(input logic fv, input logic [63:0] pc, input logic [31:0] i0, i1,
                      input logic v0, v1, st, fl);
    fetch_valid = fv; fetch_pc = pc; fetch_inst0 = i0; fetch_inst1 = i1;
    fetch_v0 = v0; fetch_v1 = v1; StallD = st; FlushD = fl;
    @(posedge clk); #1;
    fetch_valid = 0; fetch_v0 = 0; fetch_v1 = 0; StallD = 0; FlushD = 0;
  endtask

  task automatic idle(input logic st);
    step(0, '0, '0, '0, 0, 0, st, 0);
  endtask

  logic [63:0] dPc1 [4] = '{64'h4000, 64'h4008, 64'h4010, 64'h4018};
  logic        dEn2 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int sent, issued, cyc;
    logic st, fv;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", enableD, 0);
    chk("rst_en2", enableD2, 0);
    chk("rst_instr1", InstrD1, 0);
    chk("rst_pc1", PCD1, 0);
    chk("rst_pc2", PCD2, 0);
    chk("rst_ready", fetch_ready, 1);
    reset = 0;

    // independent pair
    step(1, 64'h1000, ADD1, ADD4, 1, 1, 0, 0);
    chk("nobypass_en", enableD, 0);
    idle(0);
    chk("pair_en", enableD, 1);
    chk("pair_en2", enableD2, 1);
    chk("pair_pc1", PCD1, 64'h1000);
    chk("pair_pc2", PCD2, 64'h1004);
    chk("pair_i1", InstrD1, ADD1);
    chk("pair_i2", InstrD2, ADD4);
    idle(0);
    chk("empty_en", enableD, 0);
    chk("empty_pc1", PCD1, 0);

    // RAW-dependent pair splits
    step(1, 64'h1100, ADDI5, ADD6, 1, 1, 0, 0);
    idle(0);
    chk("raw_en", enableD, 1);
    chk("raw_en2", enableD2, 0);
    chk("raw_i1", InstrD1, ADDI5);
    chk("raw_pc2", PCD2, 0);
    idle(0);
    chk("raw2_i1", InstrD1, ADD6);
    chk("raw2_pc1", PCD1, 64'h1104);
    chk("raw2_en2", enableD2, 0);

    // ecall issued alone, as second and as first of a pair
    step(1, 64'h2000, NOP, ECALL, 1, 1, 0, 0);
    step(1, 64'h2008, ADD1, ADD4, 1, 1, 0, 0);
    chk("ec_nop_pc", PCD1, 64'h2000);
    chk("ec_nop_en2", enableD2, 0);
    idle(0);
    chk("ec_i1", InstrD1, ECALL);
    chk("ec_pc1", PCD1, 64'h2004);
    chk("ec_en2", enableD2, 0);
    idle(0);
    chk("ec_next_pc1", PCD1, 64'h2008);
    chk("ec_next_pc2", PCD2, 64'h200C);

    // stall while filling to 7; D stays frozen on the 0x2008 pair
    step(1, 64'h4000, NOP, NOP, 1, 0, 1, 0);
    chk("stl_pc1", PCD1, 64'h2008);
    chk("stl_ready1", fetch_ready, 1);
    step(1, 64'h4004, NOP, NOP, 1, 1, 1, 0);
    step(1, 64'h400C, NOP, NOP, 1, 1, 1, 0);
    chk("stl_ready5", fetch_ready, 1);
    step(1, 64'h4014, NOP, NOP, 1, 1, 1, 0);
    chk("stl_ready7", fetch_ready, 0);
    chk("stl_pc1b", PCD1, 64'h2008);
    chk("stl_en2", enableD2, 1);
    step(1, 64'h5000, NOP, NOP, 1, 1, 1, 0);
    chk("stl_full_ready", fetch_ready, 0);
    for (int i = 0; i < 4; i++) begin
      idle(0);
      chk("drain_pc1", PCD1, dPc1[i]);
      chk("drain_en2", enableD2, dEn2[i]);
      if (dEn2[i]) chk("drain_pc2", PCD2, dPc1[i] + 64'd4);
    end
    idle(0);
    chk("drain_end_en", enableD, 0);

    // flush overrides stall and drops the same-cycle bundle
    step(1, 64'h6000, NOP, NOP, 1, 1, 1, 0);
    step(1, 64'h6008, NOP, NOP, 1, 1, 1, 0);
    step(1, 64'h6010, NOP, NOP, 1, 0, 1, 0);
    step(1, 64'h7000, NOP, NOP, 1, 1, 1, 1);
    chk("fl_en", enableD, 0);
    chk("fl_ready", fetch_ready, 1);
    idle(0);
    chk("fl_empty_en", enableD, 0);
    step(1, 64'h3000, NOP, NOP, 1, 1, 0, 0);
    chk("fl_acc_en", enableD, 0);
    idle(0);
    chk("fl_new_en", enableD, 1);
    chk("fl_new_pc1", PCD1, 64'h3000);

    // stream 20 bundles with random stalls; pointers wrap several times
    sent = 0; issued = 0; cyc = 0;
    while ((issued < 40 || sent < 20) && cyc < 400) begin
      fv = (sent < 20) && fetch_ready;
      st = ($urandom_range(0, 3) == 0);
      step(fv, 64'h8000 + 64'(sent) * 8, NOP, NOP, fv, fv, st, 0);
      if (fv) begin
        expQ.push_back(64'h8000 + 64'(sent) * 8);
        expQ.push_back(64'h8000 + 64'(sent) * 8 + 4);
        sent++;
      end
      if (!st && enableD) begin
        chk("str_pc1", PCD1, (expQ.size() != 0) ? expQ.pop_front() : 64'hDEAD);
        issued++;
        if (enableD2) begin
          chk("str_pc2", PCD2, (expQ.size() != 0) ? expQ.pop_front() : 64'hDEAD);
          issued++;
        end
      end
      cyc++;
    end
    chk("str_issued", 64'(issued), 64'd40);
    chk("str_left", 64'(expQ.size()), 64'd0);

    // reset wins over stall and fetch
    step(1, 64'h9000, NOP, NOP, 1, 1, 0, 0);
    reset = 1;
    step(1, 64'h9008, NOP, NOP, 1, 1, 1, 0);
    reset = 0;
    chk("rst2_en", enableD, 0);
    chk("rst2_pc1", PCD1, 0);
    chk("rst2_ready", fetch_ready, 1);
    idle(0);
    chk("rst2_empty", enableD, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
